// File: rtl/loop_mix_pwm.sv
// Loop-bank mixer: sums one frame of bank samples plus live input, saturates to 16 bits,
// and renders the latest mix as a single-bit PWM stream for the audio amplifier.
module loop_mix_pwm #(
  parameter int          NBANK = 8,
  parameter logic [15:0] MID   = 16'h8000,
  parameter int          PWM_W = 11
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             data_ready,
  input  logic [15:0]      mem_dq_o,
  input  logic [2:0]       bank,
  input  logic [NBANK-1:0] active,
  input  logic [15:0]      live_in,
  input  logic             audio_en,
  output logic [15:0]      mix_out,
  output logic             mix_valid,
  output logic [7:0]       seq_err_cnt,
  output logic             AUD_PWM,
  output logic             AUD_SD
);

  localparam logic [2:0]       LAST_BANK = 3'(NBANK - 1);
  localparam logic [PWM_W-1:0] PCNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_RST  = {1'b1, {(PWM_W-1){1'b0}}};

  logic signed [19:0] acc_q, acc_d;
  logic [2:0]         exp_q, exp_d;
  logic [15:0]        mix_q, mix_d;
  logic               valid_q, valid_d;
  logic [7:0]         err_q, err_d;
  logic [PWM_W-1:0]   pcnt_q, duty_q;
  logic               pwm_q, sd_q;

  logic signed [16:0] bank_term, live_term;
  logic signed [19:0] sum;
  logic [15:0]        sat;

  // Offset-binary to signed: widen to 17 bits so the full 0..FFFF range subtracts cleanly.
  always_comb begin
    bank_term = '0;
    if (active[bank])
      bank_term = $signed({1'b0, mem_dq_o}) - $signed({1'b0, MID});
    live_term = $signed({1'b0, live_in}) - $signed({1'b0, MID});
    sum = acc_q + {{3{bank_term[16]}}, bank_term} + {{3{live_term[16]}}, live_term};
    if (sum > 20'sd32767)
      sat = 16'h7FFF;
    else if (sum < -20'sd32768)
      sat = 16'h8000;
    else
      sat = sum[15:0];
  end

  always_comb begin
    acc_d   = acc_q;
    exp_d   = exp_q;
    mix_d   = mix_q;
    valid_d = 1'b0;
    err_d   = err_q;
    if (data_ready) begin
      if (bank != exp_q) begin
        // Out-of-sequence beat: abandon the frame and resynchronise on bank 0.
        acc_d = '0;
        exp_d = '0;
        if (err_q != 8'hFF)
          err_d = err_q + 8'd1;
      end else if (exp_q == LAST_BANK) begin
        acc_d   = '0;
        exp_d   = '0;
        mix_d   = sat + MID;
        valid_d = 1'b1;
      end else begin
        acc_d = acc_q + {{3{bank_term[16]}}, bank_term};
        exp_d = exp_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      acc_q   <= '0;
      exp_q   <= '0;
      mix_q   <= MID;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      exp_q   <= exp_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Duty reloads only at the period boundary from the registered mix, so a
  // simultaneous mix update is picked up one period later.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      pcnt_q <= '0;
      duty_q <= DUTY_RST;
      pwm_q  <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_q + PWM_W'(1);
      if (pcnt_q == PCNT_MAX)
        duty_q <= mix_q[15 -: PWM_W];
      pwm_q  <= audio_en && (pcnt_q < duty_q);
      sd_q   <= audio_en;
    end
  end

  assign mix_out     = mix_q;
  assign mix_valid   = valid_q;
  assign seq_err_cnt = err_q;
  assign AUD_PWM     = pwm_q;
  assign AUD_SD      = sd_q;

endmodule

// File: tb/tb_loop_mix_pwm.sv
// Directed bench for loop_mix_pwm: frame mixing, saturation, sequence errors,
// mid-frame mask changes, reset recovery and PWM duty measurement.
module tb_loop_mix_pwm;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        data_ready = 1'b0;
  logic [15:0] mem_dq_o = '0;
  logic [2:0]  bank = '0;
  logic [7:0]  active = '0;
  logic [15:0] live_in = 16'h8000;
  logic        audio_en = 1'b0;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic [7:0]  seq_err_cnt;
  logic        AUD_PWM;
  logic        AUD_SD;

  int vectors = 0;
  int miscompares = 0;

  loop_mix_pwm dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .data_ready (data_ready),
    .mem_dq_o   (mem_dq_o),
    .bank       (bank),
    .active     (active),
    .live_in    (live_in),
    .audio_en   (audio_en),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .seq_err_cnt(seq_err_cnt),
    .AUD_PWM    (AUD_PWM),
    .AUD_SD     (AUD_SD)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
    $display("check %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One data_ready beat; returns at the negedge after the capturing posedge.
  task automatic beat(input logic [2:0] b, input logic [15:0] d,
                      input logic [7:0] act, input logic [15:0] lv);
    @(negedge clk_100MHz);
    data_ready = 1'b1;
    bank       = b;
    mem_dq_o   = d;
    active     = act;
    live_in    = lv;
    @(negedge clk_100MHz);
    data_ready = 1'b0;
  endtask

  // Banks 0/1 carry d01, the rest doth; act_lo masks beats 0..3, act_hi beats 4..7.
  task automatic frame(input string tag, input logic [7:0] act_lo, input logic [7:0] act_hi,
                       input logic [15:0] d01, input logic [15:0] doth,
                       input logic [15:0] lv, input logic [15:0] expv);
    for (int b = 0; b < 8; b++) begin
      beat(3'(b), (b < 2) ? d01 : doth, (b < 4) ? act_lo : act_hi, lv);
      if (b < 7) chk({tag, " valid idle"}, 32'(mix_valid), 32'd0);
    end
    chk({tag, " valid"}, 32'(mix_valid), 32'd1);
    chk({tag, " mix"}, 32'(mix_out), 32'(expv));
    @(negedge clk_100MHz);
    chk({tag, " valid 1-cycle"}, 32'(mix_valid), 32'd0);
  endtask

  task automatic count_high(input string tag, input int expv);
    int hi = 0;
    repeat (2048) begin
      @(negedge clk_100MHz);
      if (AUD_PWM) hi++;
    end
    chk(tag, 32'(hi), 32'(expv));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_100MHz);
    rst = 1'b0;
    chk("rst mix_out", 32'(mix_out), 32'h8000);
    chk("rst mix_valid", 32'(mix_valid), 32'd0);
    chk("rst seq_err", 32'(seq_err_cnt), 32'd0);
    chk("rst AUD_PWM", 32'(AUD_PWM), 32'd0);
    chk("rst AUD_SD", 32'(AUD_SD), 32'd0);

    // Reset duty is half scale: 1024 of 2048
    audio_en = 1'b1;
    @(negedge clk_100MHz);
    count_high("pwm reset duty", 1024);
    audio_en = 1'b0;

    // Basic two-bank frame
    frame("f031", 8'h03, 8'h03, 16'h9000, 16'h1234, 16'h8000, 16'hA000);

    // data_ready low: nothing moves even with bank==exp and garbage data
    mem_dq_o = 16'hFFFF;
    bank = 3'd0;
    active = 8'hFF;
    repeat (5) @(negedge clk_100MHz);
    chk("idle mix_out", 32'(mix_out), 32'hA000);
    chk("idle seq_err", 32'(seq_err_cnt), 32'd0);
    chk("idle valid", 32'(mix_valid), 32'd0);

    // PWM at 0xA000 -> duty 1280
    audio_en = 1'b1;
    repeat (4096) @(negedge clk_100MHz);
    chk("AUD_SD on", 32'(AUD_SD), 32'd1);
    count_high("pwm duty A000", 1280);
    audio_en = 1'b0;
    @(negedge clk_100MHz);
    chk("AUD_SD off", 32'(AUD_SD), 32'd0);
    chk("AUD_PWM off", 32'(AUD_PWM), 32'd0);
    count_high("pwm disabled", 0);

    // Positive saturation, then maximum duty 2047/2048
    frame("sat hi", 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    audio_en = 1'b1;
    repeat (4096) @(negedge clk_100MHz);
    count_high("pwm duty max", 2047);
    audio_en = 1'b0;

    // Negative saturation
    frame("sat lo", 8'hFF, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Out-of-order frame 0,1,3
    beat(3'd0, 16'h9000, 8'h03, 16'h8000);
    beat(3'd1, 16'h9000, 8'h03, 16'h8000);
    beat(3'd3, 16'h1234, 8'h03, 16'h8000);
    chk("seq err cnt", 32'(seq_err_cnt), 32'd1);
    chk("seq err valid", 32'(mix_valid), 32'd0);
    @(negedge clk_100MHz);
    chk("seq err no valid", 32'(mix_valid), 32'd0);
    chk("seq err mix held", 32'(mix_out), 32'h0000);
    frame("after err", 8'h03, 8'h03, 16'h9000, 16'h1234, 16'h8000, 16'hA000);

    // Mask changes mid-frame: bank 2 counted early, bank 5 counted late
    // 4096+4096-28108-28108+32767 = -15257 -> 0x4467
    frame("mask change", 8'h07, 8'h20, 16'h9000, 16'h1234, 16'hFFFF, 16'h4467);

    // Reset mid-frame, colliding with a valid data_ready
    for (int b = 0; b < 4; b++) beat(3'(b), 16'hFFFF, 8'hFF, 16'h8000);
    @(negedge clk_100MHz);
    rst = 1'b1;
    data_ready = 1'b1;
    bank = 3'd4;
    mem_dq_o = 16'hFFFF;
    @(negedge clk_100MHz);
    rst = 1'b0;
    data_ready = 1'b0;
    chk("mid rst mix_out", 32'(mix_out), 32'h8000);
    chk("mid rst valid", 32'(mix_valid), 32'd0);
    chk("mid rst seq_err", 32'(seq_err_cnt), 32'd0);
    chk("mid rst AUD_PWM", 32'(AUD_PWM), 32'd0);
    chk("mid rst AUD_SD", 32'(AUD_SD), 32'd0);
    frame("post rst", 8'h03, 8'h03, 16'h9000, 16'h1234, 16'h8000, 16'hA000);
    chk("post rst seq_err", 32'(seq_err_cnt), 32'd0);

    // 300 out-of-order beats saturate the error counter
    for (int i = 0; i < 300; i++) begin
      beat(3'd3, 16'h1234, 8'hFF, 16'h8000);
      if (i == 99) chk("err cnt 100", 32'(seq_err_cnt), 32'd100);
      if (i == 254) chk("err cnt 255", 32'(seq_err_cnt), 32'd255);
    end
    chk("err cnt hold", 32'(seq_err_cnt), 32'd255);
    chk("err no valid", 32'(mix_valid), 32'd0);
    chk("err mix held", 32'(mix_out), 32'hA000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
